io_console: RTL and testbench

Memory-mapped console output device occupying the I/O region (memAddr[15:12] = 4'hF) of the external memory map, sitting directly downstream of the external memory block's I/O decode. It accepts byte writes from the multicycle CPU's memory interface into a small FIFO and drains them over a valid/ready byte stream toward a host-side sink. It also exposes a status register and a free-running cycle counter. Reads return data registered on the clock edge, matching the one-cycle read latency of ROM/RAM.

---
 rtl/io_console_pkg.sv | 27 ++
 rtl/io_console_sync_fifo.sv | 49 ++++
 rtl/io_console.sv | 95 +++++++++
 tb/tb_io_console.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/io_console_pkg.sv
// Shared constants for the memory-mapped console: region tag, register offsets,
// STATUS bit layout and a helper that packs the STATUS word.
package io_console_pkg;

  localparam logic [3:0] IO_REGION  = 4'hF;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLES = 2'd2;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY     = 4;
  localparam int ST_FULL      = 5;
  localparam int ST_OVERFLOW  = 6;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic [3:0] cnt);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: 4] = cnt;
    w[ST_EMPTY]          = empty;
    w[ST_FULL]           = full;
    w[ST_OVERFLOW]       = ovf;
    return w;
  endfunction

endpackage

// File: rtl/io_console_sync_fifo.sv
// Byte FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_W);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; slots are only observed after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/io_console.sv
// Console output device in the 0xF000 I/O region: TXDATA/STATUS/CYCLES registers,
// byte FIFO drained over valid/ready, one-cycle registered reads.
module io_console
  import io_console_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [WIDTH-1:0]      memWriteData,
  output logic [WIDTH-1:0]      ioReadData,
  output logic                  txValid,
  output logic [7:0]            txData,
  input  logic                  txReady
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            sel;
  logic [1:0]      offset;
  logic            wr_tx;
  logic            wr_status;
  logic            wr_cycles;
  logic            pop;
  logic [7:0]      head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push_ok;
  logic            overflow;
  logic [31:0]     cycles;
  logic [7:0]      last_byte;
  logic [3:0]      count4;
  logic [WIDTH-1:0] rd_mux;
  logic            unused_addr;

  assign sel       = (memAddr[ADDR_WIDTH-1 -: 4] == IO_REGION);
  assign offset    = memAddr[3:2];
  assign wr_tx     = sel & MemWrite & (offset == OFF_TXDATA);
  assign wr_status = sel & MemWrite & (offset == OFF_STATUS);
  assign wr_cycles = sel & MemWrite & (offset == OFF_CYCLES);
  assign pop       = txValid & txReady;
  assign unused_addr = ^{memAddr[ADDR_WIDTH-5:4], memAddr[1:0]};

  sync_fifo #(.DEPTH(DEPTH), .DW(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (memWriteData[7:0]),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .push_ok   (push_ok)
  );

  assign txValid = ~empty;
  // When drained, the bus keeps showing the byte most recently handed to the sink.
  assign txData  = empty ? last_byte : head;
  assign count4  = 4'(count);

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_STATUS: rd_mux = status_word(overflow, full, empty, count4);
      OFF_CYCLES: rd_mux = cycles;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      cycles     <= '0;
      last_byte  <= '0;
      ioReadData <= '0;
    end else begin
      // A dropped push wins over a clearing write on the same edge.
      if (wr_tx & ~push_ok)  overflow <= 1'b1;
      else if (wr_status)    overflow <= 1'b0;

      cycles <= wr_cycles ? memWriteData : cycles + 32'd1;

      if (pop) last_byte <= head;

      if (sel & ~MemWrite) ioReadData <= rd_mux;
    end
  end

endmodule

// File: tb/tb_io_console.sv
// Directed bench for io_console: register reads, FIFO fill/drain, overflow,
// counter load/wrap, address aliasing and mid-stream reset.
module tb_io_console;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [15:0] memAddr = 16'h0000;
  logic [31:0] memWriteData = '0;
  logic [31:0] ioReadData;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady = 1'b0;

  int tests = 0;
  int fails = 0;

  io_console dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .ioReadData   (ioReadData),
    .txValid      (txValid),
    .txData       (txData),
    .txReady      (txReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    memAddr = a; memWriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0; memAddr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    memAddr = a; MemWrite = 1'b0;
    tick();
    memAddr = 16'h0000;
  endtask

  initial begin
    // Reset with a CYCLES read already presented, released between edges.
    memAddr = 16'hF008;
    #12 reset = 1'b1;
    tick();
    check("rst_rdata_cycles0", ioReadData, 32'h0);
    check("rst_txvalid", {31'b0, txValid}, 32'h0);
    check("rst_txdata", {24'b0, txData}, 32'h0);
    tick();
    check("cycles_1", ioReadData, 32'h1);
    memAddr = 16'h0000;
    tick();
    check("rdata_hold", ioReadData, 32'h1);
    rd(16'hF008);
    check("cycles_3", ioReadData, 32'h3);

    // Three bytes, then drain.
    wr(16'hF000, 32'h41);
    check("push_lat_valid", {31'b0, txValid}, 32'h1);
    check("push_lat_data", {24'b0, txData}, 32'h41);
    wr(16'hF000, 32'hFFFF_FF42);
    wr(16'hF000, 32'h43);
    rd(16'hF004);
    check("status_3", ioReadData, 32'h3);
    txReady = 1'b1;
    check("drain_0", {24'b0, txData}, 32'h41);
    tick();
    check("drain_1", {24'b0, txData}, 32'h42);
    tick();
    check("drain_2", {24'b0, txData}, 32'h43);
    tick();
    check("drain_empty", {31'b0, txValid}, 32'h0);
    check("drain_hold", {24'b0, txData}, 32'h43);
    txReady = 1'b0;
    rd(16'hF004);
    check("status_empty", ioReadData, 32'h10);

    // Fill to full, overflow, clear.
    for (int i = 0; i < 8; i++) wr(16'hF000, 32'h10 + i);
    rd(16'hF004);
    check("status_full", ioReadData, 32'h28);
    check("full_head", {24'b0, txData}, 32'h10);
    wr(16'hF000, 32'h99);
    rd(16'hF004);
    check("status_ovf", ioReadData, 32'h68);
    wr(16'hF004, 32'h0);
    check("write_no_rdata", ioReadData, 32'h68);
    rd(16'hF004);
    check("status_clr", ioReadData, 32'h28);
    check("drop_kept_head", {24'b0, txData}, 32'h10);

    // Full FIFO with push and pop on every edge.
    txReady = 1'b1;
    memAddr = 16'hF000; memWriteData = 32'h55; MemWrite = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("pp_head", {24'b0, txData}, (k < 8) ? 32'h10 + k : 32'h55);
    end
    MemWrite = 1'b0; txReady = 1'b0;
    rd(16'hF004);
    check("pp_status", ioReadData, 32'h28);
    txReady = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    txReady = 1'b0;
    check("pp_drained_data", {24'b0, txData}, 32'h55);
    rd(16'hF004);
    check("pp_status_empty", ioReadData, 32'h10);

    // Counter load and wrap.
    wr(16'hF008, 32'hFFFF_FFFE);
    tick(); tick(); tick();
    rd(16'hF008);
    check("cycles_wrap", ioReadData, 32'h1);
    rd(16'hF00C);
    check("reserved_rd", ioReadData, 32'h0);
    rd(16'hF008);
    rd(16'hF010);
    check("alias_txdata", ioReadData, 32'h0);
    rd(16'hF014);
    check("alias_status", ioReadData, 32'h10);
    rd(16'h7004);
    check("unselected_hold", ioReadData, 32'h10);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) wr(16'hF000, 32'hA0 + i);
    txReady = 1'b1;
    tick();
    check("mid_head", {24'b0, txData}, 32'hA1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, txValid}, 32'h0);
    check("rst_async_data", {24'b0, txData}, 32'h0);
    check("rst_async_rdata", ioReadData, 32'h0);
    txReady = 1'b0;
    #3 reset = 1'b1;
    rd(16'hF004);
    check("rst_status", ioReadData, 32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
